mio_bus_ctrl: RTL and testbench

- Memory/IO bus controller directly downstream of the multi-cycle control FSM.
- Consumes the CPU's CPU_MIO/MemRead/MemWrite strobes, address and write data.
- Decodes each access to block RAM or the peripheral bus, inserts wait states, and returns read data plus the MIO_ready pulse the control FSM stalls on in IF, MEM_RD and MEM_WD.

---
 rtl/mio_pkg.sv | 16 +
 rtl/mio_wait_timer.sv | 44 ++++
 rtl/mio_bus_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus controller.
package mio_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_IO_ACC  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0]  IO_REGION_DEFAULT = 4'hE;
  localparam logic [31:0] ERR_RDATA         = 32'h0000_0000;

endpackage

// File: rtl/mio_wait_timer.sv
// Loadable wait counter shared by the RAM wait-state count (down) and the
// IO timeout count (up). Direction is captured on load.
module mio_wait_timer
  import mio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_up,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] limit,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             up_q, up_d;

  always_comb begin
    count_d = count_q;
    up_d    = up_q;
    if (load) begin
      count_d = load_val;
      up_d    = load_up;
    end else if (en) begin
      count_d = up_q ? count_q + 8'd1 : count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      up_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      up_q    <= up_d;
    end
  end

  assign term = up_q ? (count_q == limit) : (count_q == 8'd0);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to RAM or the peripheral bus,
// inserts wait states, returns read data with a one-cycle mio_ready pulse.
// Define MIO_ALIGN_CHECK_EN to reject misaligned (addr[1:0] != 0) requests.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int         RAM_WAIT   = 1,
  parameter logic [3:0] IO_BASE    = IO_REGION_DEFAULT,
  parameter int         IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mio,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  output logic        mio_ready,
  output logic        bus_err,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [31:0] io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [31:0] io_dout,
  input  logic [31:0] io_din,
  input  logic        io_ack
);

  localparam logic [CNT_W-1:0] RAM_WAIT_C = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] TO_LIMIT_C = CNT_W'(IO_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] cpu_data_in_q, cpu_data_in_d;
  logic        mio_ready_q, mio_ready_d;
  logic        bus_err_q, bus_err_d;
  logic [9:0]  ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_din_q, ram_din_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic        io_rd_q, io_rd_d;
  logic        io_wr_q, io_wr_d;
  logic [31:0] io_dout_q, io_dout_d;

  logic             tmr_load_s, tmr_up_s, tmr_en_s, tmr_term_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             misaligned_s;

`ifdef MIO_ALIGN_CHECK_EN
  assign misaligned_s = (addr_bus[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  mio_wait_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_up  (tmr_up_s),
    .load_val (tmr_val_s),
    .limit    (TO_LIMIT_C),
    .en       (tmr_en_s),
    .term     (tmr_term_s)
  );

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    cpu_data_in_d = cpu_data_in_q;
    mio_ready_d   = 1'b0;
    bus_err_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 1'b0;
    ram_din_d     = ram_din_q;
    io_addr_d     = io_addr_q;
    io_rd_d       = io_rd_q;
    io_wr_d       = io_wr_q;
    io_dout_d     = io_dout_q;
    tmr_load_s    = 1'b0;
    tmr_up_s      = 1'b0;
    tmr_en_s      = 1'b0;
    tmr_val_s     = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_mio && (mem_r ^ mem_w)) begin
          if (misaligned_s) begin
            state_d       = ST_DONE;
            mio_ready_d   = 1'b1;
            bus_err_d     = 1'b1;
            cpu_data_in_d = ERR_RDATA;
          end else if (addr_bus[31:28] == IO_BASE) begin
            state_d    = ST_IO_ACC;
            wr_d       = mem_w;
            io_addr_d  = addr_bus;
            io_dout_d  = cpu_data_out;
            io_rd_d    = mem_r;
            io_wr_d    = mem_w;
            tmr_load_s = 1'b1;
            tmr_up_s   = 1'b1;
          end else begin
            state_d    = ST_RAM_ACC;
            wr_d       = mem_w;
            ram_addr_d = addr_bus[11:2];
            ram_din_d  = cpu_data_out;
            ram_we_d   = mem_w;
            tmr_load_s = 1'b1;
            tmr_val_s  = RAM_WAIT_C;
          end
        end else if (cpu_mio && mem_r && mem_w) begin
          state_d     = ST_DONE;
          mio_ready_d = 1'b1;
          bus_err_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAM_ACC: begin
        if (tmr_term_s) begin
          if (!wr_q) begin
            cpu_data_in_d = ram_dout;
          end else begin
            cpu_data_in_d = cpu_data_in_q;
          end
          state_d     = ST_DONE;
          mio_ready_d = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      // An ack arriving on the timeout cycle still completes the access cleanly.
      ST_IO_ACC: begin
        if (io_ack) begin
          if (!wr_q) begin
            cpu_data_in_d = io_din;
          end else begin
            cpu_data_in_d = cpu_data_in_q;
          end
          io_rd_d     = 1'b0;
          io_wr_d     = 1'b0;
          state_d     = ST_DONE;
          mio_ready_d = 1'b1;
        end else if (tmr_term_s) begin
          io_rd_d       = 1'b0;
          io_wr_d       = 1'b0;
          cpu_data_in_d = ERR_RDATA;
          state_d       = ST_DONE;
          mio_ready_d   = 1'b1;
          bus_err_d     = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      cpu_data_in_q <= 32'h0000_0000;
      mio_ready_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      ram_addr_q    <= 10'd0;
      ram_we_q      <= 1'b0;
      ram_din_q     <= 32'h0000_0000;
      io_addr_q     <= 32'h0000_0000;
      io_rd_q       <= 1'b0;
      io_wr_q       <= 1'b0;
      io_dout_q     <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      cpu_data_in_q <= cpu_data_in_d;
      mio_ready_q   <= mio_ready_d;
      bus_err_q     <= bus_err_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_din_q     <= ram_din_d;
      io_addr_q     <= io_addr_d;
      io_rd_q       <= io_rd_d;
      io_wr_q       <= io_wr_d;
      io_dout_q     <= io_dout_d;
    end
  end

  assign cpu_data_in = cpu_data_in_q;
  assign mio_ready   = mio_ready_q;
  assign bus_err     = bus_err_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_din     = ram_din_q;
  assign io_addr     = io_addr_q;
  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;
  assign io_dout     = io_dout_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed plan cases plus randomized
// accesses checked against a transaction-level model of latency and data.
module tb_mio_bus_ctrl;

  localparam int         RAM_WAIT   = 1;
  localparam int         IO_TIMEOUT = 15;
  localparam logic [3:0] IO_BASE    = 4'hE;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mio, mem_r, mem_w;
  logic [31:0] addr_bus, cpu_data_out, cpu_data_in;
  logic        mio_ready, bus_err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] io_addr;
  logic        io_rd, io_wr;
  logic [31:0] io_dout, io_din;
  logic        io_ack;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rdata;

  mio_bus_ctrl #(.RAM_WAIT(RAM_WAIT), .IO_BASE(IO_BASE), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_r(mem_r), .mem_w(mem_w),
    .addr_bus(addr_bus), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .mio_ready(mio_ready), .bus_err(bus_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .io_addr(io_addr), .io_rd(io_rd),
    .io_wr(io_wr), .io_dout(io_dout), .io_din(io_din), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_data_in"}, cpu_data_in, 32'h0);
    check({tag, "_mio_ready"}, 32'(mio_ready), 32'h0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    check({tag, "_ram_din"}, ram_din, 32'h0);
    check({tag, "_io_addr"}, io_addr, 32'h0);
    check({tag, "_io_strobes"}, 32'({io_rd, io_wr}), 32'h0);
    check({tag, "_io_dout"}, io_dout, 32'h0);
  endtask

  // d = IO_ACC cycle (1-based) in which io_ack is raised; 0 = never.
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdv, input int d);
    int   exp_ready, exp_we, exp_rd, exp_wr, n;
    logic exp_err, is_io, illegal, misal;
    int   ready_cyc, ready_cnt, we_cnt, rd_cnt, wr_cnt;
    logic err_seen;
    logic [31:0] data_seen, we_din, io_a_seen, io_d_seen;
    logic [9:0]  ram_a_seen, we_addr;

    illegal = r && w;
    misal   = 1'b0;
`ifdef MIO_ALIGN_CHECK_EN
    misal   = (addr[1:0] != 2'b00);
`endif
    is_io   = (addr[31:28] == IO_BASE);
    exp_we = 0; exp_rd = 0; exp_wr = 0; exp_err = 1'b0; n = 0;
    if (illegal) begin
      exp_ready = 1; exp_err = 1'b1;
    end else if (misal) begin
      exp_ready = 1; exp_err = 1'b1; model_rdata = 32'h0;
    end else if (!is_io) begin
      exp_ready = RAM_WAIT + 2; exp_we = w ? 1 : 0;
      if (r) model_rdata = rdv;
    end else begin
      if (d >= 1 && d <= IO_TIMEOUT) begin
        n = d; exp_ready = d + 1;
        if (r) model_rdata = ~rdv;
      end else begin
        n = IO_TIMEOUT; exp_ready = IO_TIMEOUT + 1; exp_err = 1'b1; model_rdata = 32'h0;
      end
      exp_rd = r ? n : 0;
      exp_wr = w ? n : 0;
    end

    ram_dout = rdv; io_din = ~rdv;
    cpu_mio = 1'b1; mem_r = r; mem_w = w; addr_bus = addr; cpu_data_out = wdata;
    io_ack = is_io ? 1'b0 : 1'($urandom);
    ready_cyc = -1; ready_cnt = 0; we_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    err_seen = 1'b0; data_seen = '0; we_din = '0; we_addr = '0; ram_a_seen = '0;
    io_a_seen = '0; io_d_seen = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mio_ready) begin
        ready_cnt++;
        if (ready_cyc < 0) begin
          ready_cyc = cyc; err_seen = bus_err; data_seen = cpu_data_in; ram_a_seen = ram_addr;
        end
      end
      if (ram_we) begin we_cnt++; we_addr = ram_addr; we_din = ram_din; end
      if (io_rd) rd_cnt++;
      if (io_wr) wr_cnt++;
      if (io_rd || io_wr) begin io_a_seen = io_addr; io_d_seen = io_dout; end
      if (ready_cyc >= 0 && cyc == ready_cyc + 1) break;
      // Garbage on the request lines mid-access must be ignored.
      cpu_mio = 1'b0; mem_r = 1'($urandom); mem_w = 1'($urandom);
      addr_bus = $urandom; cpu_data_out = $urandom;
      if (is_io) io_ack = (io_rd || io_wr) && ((rd_cnt + wr_cnt) == d);
      else       io_ack = 1'($urandom);
    end
    io_ack = 1'b0;

    check("ready_cycle", ready_cyc, exp_ready);
    check("ready_width", ready_cnt, 1);
    check("bus_err", 32'(err_seen), 32'(exp_err));
    check("cpu_data_in", data_seen, model_rdata);
    check("ram_we_cycles", we_cnt, exp_we);
    check("io_rd_cycles", rd_cnt, exp_rd);
    check("io_wr_cycles", wr_cnt, exp_wr);
    if (exp_we != 0) begin
      check("ram_we_addr", 32'(we_addr), 32'(addr[11:2]));
      check("ram_din", we_din, wdata);
    end
    if (!is_io && !illegal && !misal) check("ram_addr", 32'(ram_a_seen), 32'(addr[11:2]));
    if (n != 0) check("io_addr", io_a_seen, addr);
    if (n != 0 && w) check("io_dout", io_d_seen, wdata);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          late_ready;
    reset = 1'b1; cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    addr_bus = '0; cpu_data_out = '0; ram_dout = '0; io_din = '0; io_ack = 1'b0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_AAAA, 0);
    run_access(1'b1, 1'b0, 32'hE000_0004, 32'h0, ~32'h0000_00A5, 3);
    run_access(1'b0, 1'b1, 32'hE000_0008, 32'h0BAD_BEEF, 32'h0, 0);
    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h7777_0001, 0);
    run_access(1'b0, 1'b1, 32'hE000_000C, 32'h1111_2222, 32'h0, IO_TIMEOUT);
    run_access(1'b1, 1'b0, 32'hE000_0010, 32'h0, 32'h0F0F_0F0F, IO_TIMEOUT);
    run_access(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_0000, 32'h9999_9999, 0);
    run_access(1'b1, 1'b0, 32'h0000_0012, 32'h0, 32'h4444_4444, 0);

    // Reset in the middle of a RAM access aborts it without a ready pulse.
    cpu_mio = 1'b1; mem_r = 1'b1; mem_w = 1'b0; addr_bus = 32'h0000_0ABC; ram_dout = 32'h3C3C_3C3C;
    @(negedge clk);
    cpu_mio = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    late_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (mio_ready) late_ready++;
    end
    check("mid_reset_no_ready", late_ready, 0);
    model_rdata = 32'h0;

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 4) begin
        if (a[31:28] == IO_BASE) a[31:28] = 4'h0;
        if (kind == 0) a[1:0] = 2'b00;
        run_access(kind[0], !kind[0], a, $urandom, $urandom, 0);
      end else if (kind < 9) begin
        a[31:28] = IO_BASE;
        run_access(kind[0], !kind[0], a, $urandom, $urandom, $urandom_range(0, IO_TIMEOUT + 1));
      end else begin
        run_access(1'b1, 1'b1, a, $urandom, $urandom, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
